// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants and elaboration-time helpers for the pipelined N:1 mux.
// The helpers describe the shape of the padded mux tree: how many select bits
// each stage resolves, how many candidates enter each stage, and where each
// stage's registered candidates sit inside the flattened inter-stage bus.
// No ports (package).
// -----------------------------------------------------------------------------
package mux_pkg;

   // Widest group-mux a single stage may build; matches the native MUX32 fan-in.
   localparam int MUX_MAX_SPS = 32'sd5;

   // Ceiling log2; returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 32'sd0;
      rem    = value - 32'sd1;
      while (rem > 32'sd0) begin
         result = result + 32'sd1;
         rem    = rem / 32'sd2;
      end
      return result;
   endfunction

   // Integer ceiling division, used for the pipeline latency.
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 32'sd1) / den;
   endfunction

   // Select width; a 1-bit select is kept even when clog2 collapses to 0.
   function automatic int sel_width(input int num_in);
      if (clog2(num_in) < 32'sd1) begin
         return 32'sd1;
      end else begin
         return clog2(num_in);
      end
   endfunction

   // Select bits consumed by a stage; the last stage takes whatever remains.
   function automatic int stage_bits(input int sel_w, input int sps, input int stage);
      int rem;
      rem = sel_w - (stage * sps);
      if (rem < 32'sd0) begin
         rem = 32'sd0;
      end else begin
         rem = rem;
      end
      if (rem > sps) begin
         return sps;
      end else begin
         return rem;
      end
   endfunction

   // Candidates entering a stage (the tree is padded to a power of two).
   function automatic int stage_cands(input int sel_w, input int sps, input int stage);
      int used;
      used = stage * sps;
      if (used > sel_w) begin
         used = sel_w;
      end else begin
         used = used;
      end
      return 32'sd1 << (sel_w - used);
   endfunction

   // Bit offset of the candidates entering a stage (stage >= 1) inside the
   // inter-stage bus; stage k's registered output lives at stage_offset(k+1).
   function automatic int stage_offset(input int sel_w, input int sps, input int width,
                                       input int stage);
      int off;
      off = 32'sd0;
      for (int k = 32'sd1; k < stage; k++) begin
         off = off + stage_cands(sel_w, sps, k) * width;
      end
      return off;
   endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// -----------------------------------------------------------------------------
// mux_pipe_stage
// One registered 2^SB:1 group-mux level of the pipelined mux tree. The N_IN
// candidates are split into groups of 2^SB consecutive entries; the low SB
// select bits pick one entry per group. The remaining select bits are shifted
// down and registered alongside the data and the valid bit.
// With HOLD_LAST set (final stage) data only loads on a valid sample, so the
// output keeps the last valid value while the valid bit still follows.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high clear of all stage registers
//   ce     in   clock enable; 0 holds every register
//   d_i    in   N_IN*WIDTH candidate data
//   sel_i  in   SEL_W unconsumed select bits, LSB first
//   v_i    in   valid bit travelling with the data
//   d_o    out  N_OUT*WIDTH registered reduced candidates
//   sel_o  out  SEL_W registered remaining select bits
//   v_o    out  registered valid bit
// -----------------------------------------------------------------------------
module mux_pipe_stage
   import mux_pkg::*;
#(
   parameter int N_IN      = 32,
   parameter int WIDTH     = 1,
   parameter int SB        = 2,
   parameter int SEL_W     = 5,
   parameter bit HOLD_LAST = 1'b0,
   localparam int N_OUT    = ceil_div(N_IN, 32'sd1 << SB)
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ce,
   input  logic [N_IN*WIDTH-1:0]    d_i,
   input  logic [SEL_W-1:0]         sel_i,
   input  logic                     v_i,
   output logic [N_OUT*WIDTH-1:0]   d_o,
   output logic [SEL_W-1:0]         sel_o,
   output logic                     v_o
);

   logic [SB-1:0]          lane_s;
   logic [N_OUT*WIDTH-1:0] mux_s;
   logic [N_OUT*WIDTH-1:0] d_d;
   logic [N_OUT*WIDTH-1:0] d_q;
   logic [SEL_W-1:0]       sel_d;
   logic [SEL_W-1:0]       sel_q;
   logic                   v_d;
   logic                   v_q;

   assign lane_s = sel_i[SB-1:0];

   // Group mux: each output group takes the lane addressed by this stage's bits.
   always_comb begin
      mux_s = '0;
      for (int g = 32'sd0; g < N_OUT; g++) begin
         if (((g << SB) + int'(lane_s)) < N_IN) begin
            mux_s[g*WIDTH +: WIDTH] = d_i[((g << SB) + int'(lane_s))*WIDTH +: WIDTH];
         end else begin
            mux_s[g*WIDTH +: WIDTH] = '0;
         end
      end
   end

   // Next-state: everything advances on ce; the final stage gates data by valid.
   always_comb begin
      d_d   = d_q;
      sel_d = sel_q;
      v_d   = v_q;
      if (ce) begin
         v_d   = v_i;
         sel_d = sel_i >> SB;
         if (!HOLD_LAST || v_i) begin
            d_d = mux_s;
         end else begin
            d_d = d_q;
         end
      end else begin
         d_d   = d_q;
         sel_d = sel_q;
         v_d   = v_q;
      end
   end

   // Stage registers with synchronous clear that takes priority over ce.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_q   <= '0;
         sel_q <= '0;
         v_q   <= 1'b0;
      end else begin
         d_q   <= d_d;
         sel_q <= sel_d;
         v_q   <= v_d;
      end
   end

   assign d_o   = d_q;
   assign sel_o = sel_q;
   assign v_o   = v_q;

endmodule

// File: rtl/mux_pipe.sv
// -----------------------------------------------------------------------------
// mux_pipe
// Parametrised pipelined NUM_IN:1 multiplexer of WIDTH-bit channels. The
// select is resolved SPS bits per registered stage (LSB first), giving a
// latency of LAT = ceil(SEL_W/SPS) CE-qualified cycles. Leaves above NUM_IN
// are tied to zero, so an out-of-range select yields O = 0 with VO = VI.
// The output holds the last valid sample while VO follows the valid pipeline.
//
// Ports:
//   CLK    in   rising-edge clock
//   RESET  in   synchronous active-high reset, overrides CE
//   CE     in   clock enable; 0 stalls the whole pipeline
//   I      in   NUM_IN*WIDTH flattened channels, channel k at [k*WIDTH +: WIDTH]
//   S      in   SEL_W channel select, sampled with I
//   VI     in   input valid
//   O      out  WIDTH selected data, registered
//   VO     out  output valid, registered
// -----------------------------------------------------------------------------
module mux_pipe
   import mux_pkg::*;
#(
   parameter int NUM_IN   = 32,
   parameter int WIDTH    = 1,
   parameter int SPS      = 2,
   localparam int SEL_W   = sel_width(NUM_IN)
)
(
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     CE,
   input  logic [NUM_IN*WIDTH-1:0]  I,
   input  logic [SEL_W-1:0]         S,
   input  logic                     VI,
   output logic [WIDTH-1:0]         O,
   output logic                     VO
);

   localparam int LAT   = ceil_div(SEL_W, SPS);
   localparam int N_PAD = 32'sd1 << SEL_W;
   localparam int BUS_W = stage_offset(SEL_W, SPS, WIDTH, LAT + 32'sd1);

   logic [N_PAD*WIDTH-1:0] pad_s;
   logic [BUS_W-1:0]       tree_s;
   logic [SEL_W-1:0]       sel_s [0:LAT];
   logic [LAT:0]           vld_s;
   logic [SEL_W-1:0]       sel_unused_s;

   // Zero-pad the leaves past the last real channel to complete the tree.
   always_comb begin
      pad_s                     = '0;
      pad_s[NUM_IN*WIDTH-1:0]   = I;
   end

   assign sel_s[0] = S;
   assign vld_s[0] = VI;

   generate
      for (genvar j = 0; j < LAT; j++) begin : g_stage
         localparam int C_IN  = stage_cands(SEL_W, SPS, j);
         localparam int C_OUT = stage_cands(SEL_W, SPS, j + 1);
         localparam int SB    = stage_bits(SEL_W, SPS, j);

         logic [C_IN*WIDTH-1:0] d_in_s;

         if (j == 0) begin : g_head
            assign d_in_s = pad_s;
         end else begin : g_body
            assign d_in_s = tree_s[stage_offset(SEL_W, SPS, WIDTH, j) +: C_IN*WIDTH];
         end

         mux_pipe_stage #(
            .N_IN      (C_IN),
            .WIDTH     (WIDTH),
            .SB        (SB),
            .SEL_W     (SEL_W),
            .HOLD_LAST (j == LAT - 1)
         ) u_stage (
            .clk   (CLK),
            .reset (RESET),
            .ce    (CE),
            .d_i   (d_in_s),
            .sel_i (sel_s[j]),
            .v_i   (vld_s[j]),
            .d_o   (tree_s[stage_offset(SEL_W, SPS, WIDTH, j + 1) +: C_OUT*WIDTH]),
            .sel_o (sel_s[j+1]),
            .v_o   (vld_s[j+1])
         );
      end
   endgenerate

   // Every select bit has been consumed after the last stage.
   assign sel_unused_s = sel_s[LAT];

   assign O  = tree_s[stage_offset(SEL_W, SPS, WIDTH, LAT) +: WIDTH];
   assign VO = vld_s[LAT];

endmodule
